// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl
// Brief    : Instruction-fetch sequencer. It keeps one read outstanding to
//            instruction memory, holds returned words in a 2-entry buffer and
//            discards in-flight data when execute redirects the PC.
//            IFETCH_PREFETCH_EN lets fetch run up to two entries ahead of decode.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] instr_addr,
    output logic [31:0] rom_instr
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_req_addr;
    logic [31:0] w_req_addr_nxt;
    logic [1:0]  r_count;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_plus4;
    logic [1:0]  w_cnt_pop;
    logic [1:0]  w_cnt_push;
    logic        w_room_idle;
    logic        w_room_req;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_pc_plus4    = r_fetch_pc + 32'd4;
    assign w_push        = (r_state == S_REQ) && imem_resp && !redirect;
    assign w_pop         = (r_count != 2'd0) && id_ready && !redirect;
    assign w_cnt_pop     = r_count - {1'b0, w_pop};
    assign w_cnt_push    = w_cnt_pop + 2'd1;

    // Room is judged on the occupancy this edge will leave behind.
`ifdef IFETCH_PREFETCH_EN
    assign w_room_idle = (w_cnt_pop < 2'd2);
    assign w_room_req  = (w_cnt_push < 2'd2);
`else
    assign w_room_idle = (w_cnt_pop == 2'd0);
    assign w_room_req  = (w_cnt_push == 2'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                end else if (w_room_idle) begin
                    w_req_addr_nxt = r_fetch_pc;
                    w_state_nxt    = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_resp && !redirect) begin
                    w_fetch_pc_nxt = w_pc_plus4;
                    if (w_room_req) begin
                        w_req_addr_nxt = w_pc_plus4;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (imem_resp) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_req_addr_nxt = w_redirect_pc;
                end else if (redirect) begin
                    // The issued read cannot be withdrawn; wait out its response.
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                end
                if (imem_resp) begin
                    w_req_addr_nxt = redirect ? w_redirect_pc : r_fetch_pc;
                    w_state_nxt    = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift buffer: entry 0 is always the head presented to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count         <= 2'd0;
            r_fifo_pc[0]    <= 32'd0;
            r_fifo_pc[1]    <= 32'd0;
            r_fifo_instr[0] <= 32'd0;
            r_fifo_instr[1] <= 32'd0;
        end else if (redirect) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_cnt_pop + {1'b0, w_push};
            if (w_pop) begin
                r_fifo_pc[0]    <= r_fifo_pc[1];
                r_fifo_instr[0] <= r_fifo_instr[1];
            end
            if (w_push) begin
                if (w_cnt_pop == 2'd0) begin
                    r_fifo_pc[0]    <= r_req_addr;
                    r_fifo_instr[0] <= imem_rdata;
                end else begin
                    r_fifo_pc[1]    <= r_req_addr;
                    r_fifo_instr[1] <= imem_rdata;
                end
            end
        end
    end

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_push && (r_count == 2'd2))
    );

    assign imem_read    = (r_state != S_IDLE);
    assign imem_address = r_req_addr;
    assign id_valid     = (r_count != 2'd0);
    assign instr_addr   = r_fifo_pc[0];
    assign rom_instr    = r_fifo_instr[0];

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_ctrl
// Brief    : Directed self-checking bench for ifetch_ctrl (both prefetch builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] instr_addr;
    logic [31:0] rom_instr;

    int checks = 0;
    int errors = 0;

    ifetch_ctrl #(.RESET_PC(32'h0000_0060)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .instr_addr   (instr_addr),
        .rom_instr    (rom_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Asynchronous reset from mid-cycle; outputs must change without a clock edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        imem_resp = 1'b0;
        redirect  = 1'b0;
        id_ready  = 1'b0;
        #1;
        chk("rst_read", {31'd0, imem_read}, 32'd0);
        chk("rst_addr", imem_address, 32'h60);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_iaddr", instr_addr, 32'd0);
        chk("rst_instr", rom_instr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_idle", {31'd0, imem_read}, 32'd0);
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (imem_read !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, imem_read}, 32'd1);
        chk("req_addr", imem_address, exp_addr);
    endtask

    task automatic respond(input logic [31:0] data);
        tick();
        imem_resp  = 1'b1;
        imem_rdata = data;
        tick();
        imem_resp  = 1'b0;
    endtask

    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data);
        wait_req(exp_addr);
        respond(data);
    endtask

    task automatic head(input logic [31:0] exp_addr, input logic [31:0] exp_instr);
        chk("head_valid", {31'd0, id_valid}, 32'd1);
        chk("head_addr", instr_addr, exp_addr);
        chk("head_instr", rom_instr, exp_instr);
    endtask

    initial begin
        rst_n       = 1'b1;
        imem_resp   = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        id_ready    = 1'b0;

        // Straight-line fetch with decode always ready.
        do_reset();
        tick();
        chk("first_read", {31'd0, imem_read}, 32'd1);
        chk("first_addr", imem_address, 32'h60);
        id_ready = 1'b1;
        serve(32'h60, 32'hA000_0060);
        head(32'h60, 32'hA000_0060);
        serve(32'h64, 32'hA000_0064);
        head(32'h64, 32'hA000_0064);
        serve(32'h68, 32'hA000_0068);
        head(32'h68, 32'hA000_0068);

        // Decode stalled: buffering depth depends on the prefetch build.
        do_reset();
        tick();
        serve(32'h60, 32'hB000_0060);
        head(32'h60, 32'hB000_0060);
`ifdef IFETCH_PREFETCH_EN
        serve(32'h64, 32'hB000_0064);
        head(32'h60, 32'hB000_0060);
        chk("full_read", {31'd0, imem_read}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            head(32'h60, 32'hB000_0060);
            chk("full_hold", {31'd0, imem_read}, 32'd0);
        end
        id_ready = 1'b1;
        tick();
        head(32'h64, 32'hB000_0064);
        chk("resume_read", {31'd0, imem_read}, 32'd1);
        chk("resume_addr", imem_address, 32'h68);
        tick();
        chk("drain_valid", {31'd0, id_valid}, 32'd0);
        chk("drain_addr", imem_address, 32'h68);
        id_ready = 1'b0;
`else
        chk("one_read", {31'd0, imem_read}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            head(32'h60, 32'hB000_0060);
            chk("one_hold", {31'd0, imem_read}, 32'd0);
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("resume_read", {31'd0, imem_read}, 32'd1);
        chk("resume_addr", imem_address, 32'h64);
        chk("resume_valid", {31'd0, id_valid}, 32'd0);
        serve(32'h64, 32'hB000_0064);
        head(32'h64, 32'hB000_0064);
`endif

        // Redirect while a read is outstanding; its response is discarded.
        do_reset();
        tick();
        id_ready = 1'b1;
        serve(32'h60, 32'hC000_0060);
        head(32'h60, 32'hC000_0060);
        wait_req(32'h64);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("disc_read", {31'd0, imem_read}, 32'd1);
        chk("disc_addr1", imem_address, 32'h64);
        chk("disc_valid1", {31'd0, id_valid}, 32'd0);
        tick();
        chk("disc_addr2", imem_address, 32'h64);
        tick();
        chk("disc_addr3", imem_address, 32'h64);
        imem_resp  = 1'b1;
        imem_rdata = 32'hBAD0_0064;
        tick();
        imem_resp = 1'b0;
        chk("tgt_addr", imem_address, 32'h200);
        chk("tgt_valid", {31'd0, id_valid}, 32'd0);
        serve(32'h200, 32'hC000_0200);
        head(32'h200, 32'hC000_0200);

        // Redirect coincident with a response; low address bits are ignored.
        do_reset();
        tick();
        id_ready = 1'b1;
        serve(32'h60, 32'hD000_0060);
        head(32'h60, 32'hD000_0060);
        serve(32'h64, 32'hD000_0064);
        head(32'h64, 32'hD000_0064);
        wait_req(32'h68);
        tick();
        imem_resp   = 1'b1;
        imem_rdata  = 32'hBAD0_0068;
        redirect    = 1'b1;
        redirect_pc = 32'h302;
        tick();
        imem_resp = 1'b0;
        redirect  = 1'b0;
        chk("coin_read", {31'd0, imem_read}, 32'd1);
        chk("coin_addr", imem_address, 32'h300);
        chk("coin_valid", {31'd0, id_valid}, 32'd0);
        serve(32'h300, 32'hD000_0300);
        head(32'h300, 32'hD000_0300);

        // PC wrap at the top of the address space.
        do_reset();
        tick();
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        chk("wrap_old", imem_address, 32'h60);
        imem_resp  = 1'b1;
        imem_rdata = 32'hBAD0_0060;
        tick();
        imem_resp = 1'b0;
        serve(32'hFFFF_FFFC, 32'hE000_FFFC);
        head(32'hFFFF_FFFC, 32'hE000_FFFC);
        serve(32'h0, 32'hE000_0000);
        head(32'h0, 32'hE000_0000);

        // Asynchronous reset while a read is pending.
        do_reset();
        tick();
        serve(32'h60, 32'hF000_0060);
`ifndef IFETCH_PREFETCH_EN
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
`endif
        chk("pre_rst_read", {31'd0, imem_read}, 32'd1);
        do_reset();
        tick();
        chk("restart_addr", imem_address, 32'h60);
        id_ready = 1'b1;
        serve(32'h60, 32'hF100_0060);
        head(32'h60, 32'hF100_0060);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
